multicycle_unit_sequencer: RTL and testbench
============================================

// Module: multicycle_unit_sequencer
// PURPOSE
//  Sequences the execute stage's multi-cycle units (iterative divider, carry-less multiplier, FPU).
//  Issues exactly one start pulse per instruction and holds the pipeline stall until the unit answers.
//  Returns the result with one-cycle-or-held delivery, and drains in-flight units on a pipeline clear.
//  Sits between execute-stage decode fields and the div/clmul/fp_execute units.
// PARAMETERS
//  XLEN        32   datapath width of operands/results
//  MAX_CYCLES  64   watchdog limit in BUSY; must be >= slowest unit latency + 1
//  CNT_W       7    watchdog counter width; must hold MAX_CYCLES
// PORTS
//  clock        in   1      clock
//  reset        in   1      synchronous, active-low reset
//  req_valid    in   1      instruction in execute needs a multi-cycle unit; held until stall=0
//  req_unit     in   2      0 none, 1 div, 2 clmul, 3 fpu
//  hold         in   1      downstream stall; result must be held while 1
//  clear        in   1      pipeline flush (trap/mret/branch kill)
//  div_start    out  1      one-cycle start pulse to divider
//  clmul_start  out  1      one-cycle start pulse to clmul
//  fpu_start    out  1      one-cycle start pulse to FPU
//  div_ready    in   1      divider result valid (one cycle)
//  div_result   in   XLEN   divider result
//  clmul_ready  in   1      clmul result valid
//  clmul_result in   XLEN   clmul result
//  fpu_ready    in   1      FPU result valid
//  fpu_result   in   XLEN   FPU result
//  fpu_flags    in   5      FPU exception flags (NV,DZ,OF,UF,NX)
//  stall        out  1      execute-stage stall request
//  res_valid    out  1      res_data/res_flags valid for the current instruction
//  res_data     out  XLEN   selected unit result
//  res_flags    out  5      FPU flags; 0 for div/clmul
//  res_err      out  1      accompanies res_valid when the watchdog fired
//  timeout_err  out  1      sticky watchdog flag, cleared only by reset
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, cnt=0, captured result/flags/unit=0, timeout_err=0.
//  All combinational outputs are 0 in IDLE with req_valid=0.
//  Reset mid-operation aborts immediately; the units share the same reset.
//  States: IDLE, BUSY, DONE, DRAIN. Unit selection sel is latched at start.
//  IDLE: start = req_valid & req_unit!=0 & ~clear & ~hold.
//   - start drives the selected *_start pulse combinationally, stall=1, latches sel, cnt=0 -> BUSY.
//   - req_valid & req_unit!=0 & hold: stall=1, no start, stay IDLE.
//  BUSY: ready is sampled only here, so units must have latency >= 1. cnt increments each cycle.
//   - sel ready & ~clear: stall=0, res_valid=1; res_data/res_flags pass through combinationally and are captured.
//     Next state is IDLE if hold=0, else DONE.
//   - otherwise: stall=1.
//   - clear & ~ready -> DRAIN. clear & ready same cycle: result discarded, res_valid=0 -> IDLE.
//   - cnt==MAX_CYCLES-1 & ~ready: res_valid=1, res_err=1, res_data=0, stall=0, timeout_err<=1.
//     Next state is IDLE if hold=0, else DONE with err captured.
//  DONE: stall=0, res_valid=1 with captured data/flags/err.
//   - hold=0 -> IDLE. clear -> IDLE with res_valid forced 0 that cycle.
//   - No start in DONE; the next instruction is seen in IDLE, giving no extra bubble.
//  DRAIN: the unit is still computing a killed op.
//   - stall = req_valid & req_unit!=0; no start.
//   - Leave to IDLE on sel ready (result dropped) or on watchdog expiry (sets timeout_err).
//   - clear in DRAIN has no further effect.
//  Exactly one *_start per accepted instruction. No start while any unit is in BUSY or DRAIN.
//  Ready pulses from non-selected units are ignored.
//  req_unit changing while in BUSY is ignored; the latched sel governs.
// TESTING
//  Div request, div_ready 33 cycles later, result 0x0000_0007: one div_start, stall high 33 cycles.
//   Required: res_valid on the ready cycle with 0x7, then IDLE.
//  FPU ready with flags=5'b00001 while hold=1 for 3 cycles: res_valid and data/flags held 3 cycles, then IDLE.
//  clear 4 cycles after clmul_start: enter DRAIN; a new div request stalls with no div_start until clmul_ready.
//   Required: div_start in the cycle after clmul_ready.
//  clear coincident with div_ready: res_valid=0, state IDLE next cycle, no result captured.
//  No ready for MAX_CYCLES=64 cycles: res_err=1, res_data=0, stall drops, timeout_err stays 1 until reset.
//  reset=0 in BUSY: next cycle all outputs 0, state IDLE; a req_valid afterwards issues a fresh start.

Source files
------------

// File: rtl/multicycle_unit_sequencer_if.sv
// ---------------------------------------------------------------------------
// multicycle_unit_sequencer_if
//
// Purpose:
//   Bundles every signal exchanged between the multi-cycle unit sequencer,
//   the execute-stage decode/pipeline control, and the div/clmul/fpu units.
//
// Signal summary:
//   req_valid, req_unit[1:0], hold, clear    pipeline -> sequencer
//   div/clmul/fpu _ready, _result[XLEN-1:0]  units    -> sequencer
//   fpu_flags[4:0]                           fpu      -> sequencer
//   div/clmul/fpu _start                     sequencer -> units
//   stall, res_valid, res_data[XLEN-1:0],
//   res_flags[4:0], res_err, timeout_err     sequencer -> pipeline
//
// Modports:
//   slave  : the sequencer's view
//   master : the surrounding pipeline/unit environment's view
// ---------------------------------------------------------------------------
interface multicycle_unit_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [1:0]      req_unit;
    logic            hold;
    logic            clear;

    logic            div_start;
    logic            clmul_start;
    logic            fpu_start;

    logic            div_ready;
    logic [XLEN-1:0] div_result;
    logic            clmul_ready;
    logic [XLEN-1:0] clmul_result;
    logic            fpu_ready;
    logic [XLEN-1:0] fpu_result;
    logic [4:0]      fpu_flags;

    logic            stall;
    logic            res_valid;
    logic [XLEN-1:0] res_data;
    logic [4:0]      res_flags;
    logic            res_err;
    logic            timeout_err;

    modport slave (
        input  req_valid, req_unit, hold, clear,
        input  div_ready, div_result, clmul_ready, clmul_result,
        input  fpu_ready, fpu_result, fpu_flags,
        output div_start, clmul_start, fpu_start,
        output stall, res_valid, res_data, res_flags, res_err, timeout_err
    );

    modport master (
        output req_valid, req_unit, hold, clear,
        output div_ready, div_result, clmul_ready, clmul_result,
        output fpu_ready, fpu_result, fpu_flags,
        input  div_start, clmul_start, fpu_start,
        input  stall, res_valid, res_data, res_flags, res_err, timeout_err
    );
endinterface

// File: rtl/multicycle_unit_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_unit_sequencer
//
// Purpose:
//   Sequences the execute stage's multi-cycle units (iterative divider,
//   carry-less multiplier, FPU). Issues one start pulse per instruction,
//   stalls the pipeline until the selected unit answers, delivers the result
//   for one cycle (or holds it while downstream is stalled), and drains a
//   unit whose operation was killed by a pipeline clear.
//
// Ports:
//   clock   in  clock
//   reset   in  synchronous, active-low reset
//   bus     multicycle_unit_sequencer_if.slave (request, unit handshakes,
//           result delivery, stall and error flags)
//
// Parameters:
//   XLEN        datapath width
//   MAX_CYCLES  watchdog limit while waiting on a unit
//   CNT_W       watchdog counter width (must hold MAX_CYCLES)
// ---------------------------------------------------------------------------
module multicycle_unit_sequencer #(
    parameter int XLEN       = 32,
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic                          clock,
    input  logic                          reset,
    multicycle_unit_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [XLEN-1:0]  resData_q, resData_d;
    logic [4:0]       resFlags_q, resFlags_d;
    logic             resErr_q, resErr_d;
    logic             timeoutErr_q, timeoutErr_d;

    logic             reqNeed;
    logic             selReady;
    logic [XLEN-1:0]  selData;
    logic [4:0]       selFlags;

    assign reqNeed = bus.req_valid && (bus.req_unit != 2'd0);

    // Route the handshake of the unit latched at start; every other unit's
    // ready pulse is ignored. Only the FPU reports exception flags.
    always_comb begin
        selReady = 1'b0;
        selData  = '0;
        selFlags = '0;
        case (sel_q)
            2'd1: begin
                selReady = bus.div_ready;
                selData  = bus.div_result;
            end
            2'd2: begin
                selReady = bus.clmul_ready;
                selData  = bus.clmul_result;
            end
            2'd3: begin
                selReady = bus.fpu_ready;
                selData  = bus.fpu_result;
                selFlags = bus.fpu_flags;
            end
            default: ;
        endcase
    end

    // Next-state and output logic. Start pulses and the live result path are
    // combinational so the pipeline sees no extra bubble on either end.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        sel_d            = sel_q;
        resData_d        = resData_q;
        resFlags_d       = resFlags_q;
        resErr_d         = resErr_q;
        timeoutErr_d     = timeoutErr_q;

        bus.div_start    = 1'b0;
        bus.clmul_start  = 1'b0;
        bus.fpu_start    = 1'b0;
        bus.stall        = 1'b0;
        bus.res_valid    = 1'b0;
        bus.res_data     = '0;
        bus.res_flags    = '0;
        bus.res_err      = 1'b0;
        bus.timeout_err  = timeoutErr_q;

        case (state_q)
            IDLE: begin
                if (reqNeed) begin
                    bus.stall = 1'b1;
                    if (!bus.clear && !bus.hold) begin
                        case (bus.req_unit)
                            2'd1:    bus.div_start   = 1'b1;
                            2'd2:    bus.clmul_start = 1'b1;
                            2'd3:    bus.fpu_start   = 1'b1;
                            default: ;
                        endcase
                        sel_d   = bus.req_unit;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end

            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (selReady && !bus.clear) begin
                    bus.res_valid = 1'b1;
                    bus.res_data  = selData;
                    bus.res_flags = selFlags;
                    resData_d     = selData;
                    resFlags_d    = selFlags;
                    resErr_d      = 1'b0;
                    state_d       = bus.hold ? DONE : IDLE;
                end else if (bus.clear) begin
                    // A result arriving with the kill is simply dropped;
                    // otherwise the unit is still busy and must be drained.
                    bus.stall = 1'b1;
                    state_d   = selReady ? IDLE : DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    bus.res_valid = 1'b1;
                    bus.res_err   = 1'b1;
                    resData_d     = '0;
                    resFlags_d    = '0;
                    resErr_d      = 1'b1;
                    timeoutErr_d  = 1'b1;
                    state_d       = bus.hold ? DONE : IDLE;
                end else begin
                    bus.stall = 1'b1;
                end
            end

            DONE: begin
                bus.res_valid = !bus.clear;
                bus.res_data  = resData_q;
                bus.res_flags = resFlags_q;
                bus.res_err   = resErr_q && !bus.clear;
                if (bus.clear || !bus.hold) begin
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                // New requests wait here; no start until the killed op ends.
                bus.stall = reqNeed;
                if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (selReady) begin
                    state_d = IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    timeoutErr_d = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and capture registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            resData_q    <= '0;
            resFlags_q   <= '0;
            resErr_q     <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            resData_q    <= resData_d;
            resFlags_q   <= resFlags_d;
            resErr_q     <= resErr_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

endmodule

// File: tb/tb_multicycle_unit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_unit_sequencer
//
// Self-checking bench for multicycle_unit_sequencer. Inputs change 1ns after
// each rising edge; outputs are sampled on the falling edge. Each scenario
// predicts start counts, stall lengths, result windows and data from the
// unit latency, hold length and clear timing it chose.
// ---------------------------------------------------------------------------
module tb_multicycle_unit_sequencer;

    localparam int XLEN       = 32;
    localparam int MAX_CYCLES = 64;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] startVec;

    multicycle_unit_sequencer_if #(.XLEN(XLEN)) bus ();

    multicycle_unit_sequencer #(
        .XLEN       (XLEN),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign startVec = {bus.fpu_start, bus.clmul_start, bus.div_start};

    // Free-running clock, 10ns period.
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic rv, input logic [1:0] unit,
                                 input logic hl, input logic cl);
        bus.req_valid = rv;
        bus.req_unit  = unit;
        bus.hold      = hl;
        bus.clear     = cl;
    endtask

    // Units silent, result buses carrying random junk.
    task automatic quietUnits();
        bus.div_ready    = 1'b0;
        bus.clmul_ready  = 1'b0;
        bus.fpu_ready    = 1'b0;
        bus.div_result   = $urandom;
        bus.clmul_result = $urandom;
        bus.fpu_result   = $urandom;
        bus.fpu_flags    = 5'($urandom);
    endtask

    task automatic toSample();
        @(negedge clock);
    endtask

    task automatic toNext();
        @(posedge clock);
        #1;
    endtask

    // One complete instruction: start, unit latency `lat`, downstream hold
    // for `holdCyc` cycles starting on the result cycle, then an idle cycle.
    task automatic runOpScenario(input int unit, input int lat,
                                 input logic [XLEN-1:0] data,
                                 input logic [4:0] flags,
                                 input int holdCyc, input string tag);
        int startCnt[3];
        int stallCnt;
        int validCnt;
        int lastCyc;
        logic [4:0] expFlags;
        logic rv;
        logic hl;
        expFlags = (unit == 3) ? flags : 5'd0;
        startCnt = '{0, 0, 0};
        stallCnt = 0;
        validCnt = 0;
        lastCyc  = lat + holdCyc;
        for (int c = 0; c <= lastCyc; c++) begin
            quietUnits();
            rv = (c <= lat);
            if (c == 0)
                hl = 1'b0;
            else if (c < lat)
                hl = 1'($urandom);
            else
                hl = (c < lat + holdCyc);
            applyStimulus(rv, (c == 0) ? 2'(unit) :
                              (rv ? 2'($urandom_range(1, 3)) : 2'd0), hl, 1'b0);
            if (c >= 1 && c <= lat) begin
                if (unit != 1) bus.div_ready   = ($urandom_range(0, 3) == 0);
                if (unit != 2) bus.clmul_ready = ($urandom_range(0, 3) == 0);
                if (unit != 3) bus.fpu_ready   = ($urandom_range(0, 3) == 0);
            end
            if (c == lat) begin
                case (unit)
                    1: begin bus.div_ready = 1'b1; bus.div_result = data; end
                    2: begin bus.clmul_ready = 1'b1; bus.clmul_result = data; end
                    default: begin
                        bus.fpu_ready  = 1'b1;
                        bus.fpu_result = data;
                        bus.fpu_flags  = flags;
                    end
                endcase
            end
            toSample();
            for (int u = 0; u < 3; u++) if (startVec[u]) startCnt[u]++;
            if (bus.stall) stallCnt++;
            if (bus.res_valid) begin
                validCnt++;
                checks++;
                if ({bus.res_data, bus.res_flags, bus.res_err} !== {data, expFlags, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL %s result c=%0d: got data=%h flags=%b err=%b, want data=%h flags=%b err=0",
                             tag, c, bus.res_data, bus.res_flags, bus.res_err, data, expFlags);
                end
            end
            if (c == lat) begin
                checks++;
                if (bus.res_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s valid_on_ready: got %b, want 1", tag, bus.res_valid);
                end
            end
            toNext();
        end
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (startCnt[u] !== ((u == unit - 1) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL %s start_count[%0d]: got %0d, want %0d",
                         tag, u, startCnt[u], (u == unit - 1) ? 1 : 0);
            end
        end
        checks++;
        if (stallCnt !== lat) begin
            errors++;
            $display("[TB] FAIL %s stall_cycles: got %0d, want %0d", tag, stallCnt, lat);
        end
        checks++;
        if (validCnt !== ((holdCyc > 0) ? holdCyc + 1 : 1)) begin
            errors++;
            $display("[TB] FAIL %s valid_cycles: got %0d, want %0d", tag, validCnt,
                     (holdCyc > 0) ? holdCyc + 1 : 1);
        end
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        toSample();
        checks++;
        if ({startVec, bus.stall, bus.res_valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL %s idle_after: got starts=%b stall=%b valid=%b, want all 0",
                     tag, startVec, bus.stall, bus.res_valid);
        end
        toNext();
    endtask

    task automatic test_reset();
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) toNext();
        reset = 1'b1;
        toSample();
        checks++;
        if ({startVec, bus.stall, bus.res_valid, bus.res_err, bus.timeout_err, bus.res_data, bus.res_flags} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got starts=%b stall=%b valid=%b err=%b tout=%b data=%h, want all 0",
                     startVec, bus.stall, bus.res_valid, bus.res_err, bus.timeout_err, bus.res_data);
        end
        toNext();
    endtask

    task automatic test_div_basic();
        runOpScenario(1, 33, 32'h0000_0007, 5'd0, 0, "div_33");
    endtask

    task automatic test_fpu_hold();
        runOpScenario(3, 5, $urandom, 5'b00001, 3, "fpu_hold");
    endtask

    // Request waiting in IDLE behind a downstream hold: stall, no start.
    task automatic test_idle_hold();
        int bad = 0;
        for (int c = 0; c < 3; c++) begin
            quietUnits();
            applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
            toSample();
            if ({startVec, bus.stall} !== 4'b0001) bad++;
            toNext();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL idle_hold: got %0d bad cycles, want 0", bad);
        end
        runOpScenario(2, 2, $urandom, 5'd0, 0, "after_hold");
    endtask

    task automatic test_drain();
        int stallCnt = 0;
        int otherCnt = 0;
        logic [XLEN-1:0] d = $urandom;
        quietUnits();
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        toSample();
        checks++;
        if (startVec !== 3'b010) begin
            errors++;
            $display("[TB] FAIL drain_clmul_start: got %b, want 010", startVec);
        end
        toNext();
        for (int c = 1; c < 4; c++) begin
            quietUnits();
            applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
            toNext();
        end
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        toSample();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_clear_valid: got %b, want 0", bus.res_valid);
        end
        toNext();
        for (int k = 0; k < 6; k++) begin
            quietUnits();
            applyStimulus(1'b1, 2'd1, 1'b0, (k == 1));
            if (k == 2) bus.div_ready = 1'b1;
            if (k == 5) bus.clmul_ready = 1'b1;
            toSample();
            if (bus.stall) stallCnt++;
            if (startVec != 3'b000 || bus.res_valid) otherCnt++;
            toNext();
        end
        checks++;
        if (stallCnt !== 6) begin
            errors++;
            $display("[TB] FAIL drain_stall: got %0d, want 6", stallCnt);
        end
        checks++;
        if (otherCnt !== 0) begin
            errors++;
            $display("[TB] FAIL drain_no_start: got %0d start/valid cycles, want 0", otherCnt);
        end
        quietUnits();
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        toSample();
        checks++;
        if ({startVec, bus.stall} !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL drain_div_start: got starts=%b stall=%b, want 001/1", startVec, bus.stall);
        end
        toNext();
        quietUnits();
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        bus.div_ready  = 1'b1;
        bus.div_result = d;
        toSample();
        checks++;
        if ({bus.res_valid, bus.res_data, bus.stall} !== {1'b1, d, 1'b0}) begin
            errors++;
            $display("[TB] FAIL drain_div_result: got valid=%b data=%h stall=%b, want 1/%h/0",
                     bus.res_valid, bus.res_data, bus.stall, d);
        end
        toNext();
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        toNext();
    endtask

    task automatic test_clear_with_ready();
        logic [XLEN-1:0] d = $urandom | 32'h1;
        quietUnits();
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        toNext();
        for (int c = 1; c < 3; c++) begin
            quietUnits();
            applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
            toNext();
        end
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
        bus.div_ready = 1'b1;
        toSample();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_ready_valid: got %b, want 0", bus.res_valid);
        end
        toNext();
        quietUnits();
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
        toSample();
        checks++;
        if ({startVec, bus.res_valid} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL clear_ready_restart: got starts=%b valid=%b, want 100/0", startVec, bus.res_valid);
        end
        toNext();
        quietUnits();
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
        bus.fpu_ready  = 1'b1;
        bus.fpu_result = d;
        bus.fpu_flags  = 5'b10010;
        toSample();
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_flags} !== {1'b1, d, 5'b10010}) begin
            errors++;
            $display("[TB] FAIL clear_ready_next_result: got valid=%b data=%h flags=%b, want 1/%h/10010",
                     bus.res_valid, bus.res_data, bus.res_flags, d);
        end
        toNext();
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        toNext();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] a = $urandom;
        logic [XLEN-1:0] b = $urandom;
        int bad = 0;
        quietUnits();
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        toNext();
        quietUnits();
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        bus.div_ready  = 1'b1;
        bus.div_result = a;
        toSample();
        checks++;
        if ({bus.res_valid, bus.res_data} !== {1'b1, a}) begin
            errors++;
            $display("[TB] FAIL b2b_first: got valid=%b data=%h, want 1/%h", bus.res_valid, bus.res_data, a);
        end
        toNext();
        quietUnits();
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        toSample();
        checks++;
        if (startVec !== 3'b010) begin
            errors++;
            $display("[TB] FAIL b2b_no_bubble: got %b, want 010", startVec);
        end
        toNext();
        quietUnits();
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        bus.clmul_ready  = 1'b1;
        bus.clmul_result = b;
        toNext();
        for (int c = 0; c < 2; c++) begin
            quietUnits();
            applyStimulus(1'b1, 2'd3, (c == 0), 1'b0);
            toSample();
            if ({startVec, bus.res_valid, bus.res_data} !== {3'b000, 1'b1, b}) bad++;
            toNext();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_done_hold: got %0d bad cycles, want 0", bad);
        end
        quietUnits();
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
        toSample();
        checks++;
        if (startVec !== 3'b100) begin
            errors++;
            $display("[TB] FAIL b2b_start_after_done: got %b, want 100", startVec);
        end
        toNext();
        quietUnits();
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
        bus.fpu_ready = 1'b1;
        toNext();
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        toNext();
    endtask

    task automatic test_timeout();
        int stallCnt = 0;
        int validCnt = 0;
        for (int c = 0; c <= MAX_CYCLES; c++) begin
            quietUnits();
            bus.fpu_result  = $urandom | 32'h8000_0000;
            bus.div_ready   = 1'($urandom);
            bus.clmul_ready = 1'($urandom);
            applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
            toSample();
            if (c < MAX_CYCLES) begin
                if (bus.stall) stallCnt++;
                if (bus.res_valid) validCnt++;
            end else begin
                checks++;
                if ({bus.res_valid, bus.res_err, bus.stall, bus.res_data, bus.res_flags} !==
                    {1'b1, 1'b1, 1'b0, {XLEN{1'b0}}, 5'd0}) begin
                    errors++;
                    $display("[TB] FAIL timeout_fire: got valid=%b err=%b stall=%b data=%h flags=%b, want 1/1/0/0/0",
                             bus.res_valid, bus.res_err, bus.stall, bus.res_data, bus.res_flags);
                end
            end
            toNext();
        end
        checks++;
        if ({stallCnt, validCnt} !== {MAX_CYCLES, 0}) begin
            errors++;
            $display("[TB] FAIL timeout_wait: got stall=%0d valid=%0d, want %0d/0", stallCnt, validCnt, MAX_CYCLES);
        end
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        toSample();
        checks++;
        if ({bus.timeout_err, bus.res_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got tout=%b valid=%b, want 1/0", bus.timeout_err, bus.res_valid);
        end
        toNext();
        runOpScenario(2, 3, $urandom, 5'd0, 0, "after_timeout");
        toSample();
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_still_set: got %b, want 1", bus.timeout_err);
        end
        toNext();
    endtask

    task automatic test_reset_busy();
        quietUnits();
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        toNext();
        for (int c = 1; c < 6; c++) begin
            quietUnits();
            applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
            toNext();
        end
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        toNext();
        reset = 1'b1;
        toSample();
        checks++;
        if ({startVec, bus.stall, bus.res_valid, bus.res_err, bus.timeout_err, bus.res_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_busy_outputs: got starts=%b stall=%b valid=%b err=%b tout=%b data=%h, want all 0",
                     startVec, bus.stall, bus.res_valid, bus.res_err, bus.timeout_err, bus.res_data);
        end
        toNext();
        runOpScenario(1, 4, $urandom, 5'd0, 0, "post_reset");
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 8; i++) begin
            runOpScenario($urandom_range(1, 3), $urandom_range(1, 40), $urandom,
                          5'($urandom), $urandom_range(0, 3), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        reset = 1'b0;
        quietUnits();
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        toNext();
        test_reset();
        test_div_basic();
        test_fpu_hold();
        test_idle_hold();
        test_drain();
        test_clear_with_ready();
        test_back_to_back();
        test_random_ops();
        test_timeout();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
